// File: rtl/reg_f_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
package reg_f_pkg;

    typedef enum logic {
        CLEARING = 1'b0,
        READY    = 1'b1
    } state_t;

    // $clog2 gives 0 for a single entry; an address port is never narrower than 1 bit.
    function automatic int unsigned addr_width(input int unsigned size);
        return ($clog2(size) < 1) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/reg_f_rd_port.sv
// One registered read port: range check, zero-register override and write forwarding.
module reg_f_rd_port
    import reg_f_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SIZE     = 8,
    parameter bit          ZERO_REG = 1'b0,
    parameter int unsigned AW       = addr_width(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clearing,
    input  logic [AW-1:0]    rsel,
    input  logic [WIDTH-1:0] rdata,
    input  logic             wr_ok,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] out
);

    localparam logic [AW:0] SIZE_W = (AW + 1)'(SIZE);

    logic in_range;
    logic forced_zero;

    assign in_range    = ({1'b0, rsel} < SIZE_W);
    assign forced_zero = !in_range || (ZERO_REG && (rsel == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else if (en) begin
            if (clearing || forced_zero) begin
                out <= '0;
            end else if (wr_ok && (wsel == rsel)) begin
                out <= wdata;
            end else begin
                out <= rdata;
            end
        end
    end

endmodule

// File: rtl/reg_f_2r1w.sv
// Register file with one write port, two registered read ports and a sequential clear sweep.
module reg_f_2r1w
    import reg_f_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SIZE     = 8,
    parameter bit          ZERO_REG = 1'b0,
    localparam int unsigned AW      = addr_width(SIZE)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             WR,
    input  logic [AW-1:0]    WSEL,
    input  logic [WIDTH-1:0] IN,
    input  logic [AW-1:0]    RSEL_A,
    input  logic [AW-1:0]    RSEL_B,
    input  logic             CLR,
    output logic [WIDTH-1:0] OUT_A,
    output logic [WIDTH-1:0] OUT_B,
    output logic             BUSY
);

    localparam logic [AW:0]   SIZE_W = (AW + 1)'(SIZE);
    localparam logic [AW-1:0] LAST   = AW'(SIZE - 1);

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_nx;
    logic [WIDTH-1:0] mem [SIZE];
    logic             clearing;
    logic             wr_ok;

    assign clearing = (state == CLEARING);
    assign BUSY     = clearing;
    assign wr_ok    = !RST && EN && !clearing && WR
                    && ({1'b0, WSEL} < SIZE_W)
                    && !(ZERO_REG && (WSEL == '0));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= CLEARING;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (EN) begin
            case (state)
                CLEARING: begin
                    if (ptr == LAST) begin
                        state_nx = READY;
                    end else begin
                        ptr_nx = ptr + 1'b1;
                    end
                end
                READY: begin
                    if (CLR) begin
                        state_nx = CLEARING;
                        ptr_nx   = '0;
                    end
                end
                default: state_nx = CLEARING;
            endcase
        end
    end

    // Sweep and user write never coincide: wr_ok already excludes the clearing state.
    always_ff @(posedge CLK) begin
        if (!RST && EN && clearing) begin
            mem[ptr] <= '0;
        end else if (wr_ok) begin
            mem[WSEL] <= IN;
        end
    end

    reg_f_rd_port #(
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_port_a (
        .clk      (CLK),
        .rst      (RST),
        .en       (EN),
        .clearing (clearing),
        .rsel     (RSEL_A),
        .rdata    (mem[RSEL_A]),
        .wr_ok    (wr_ok),
        .wsel     (WSEL),
        .wdata    (IN),
        .out      (OUT_A)
    );

    reg_f_rd_port #(
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_port_b (
        .clk      (CLK),
        .rst      (RST),
        .en       (EN),
        .clearing (clearing),
        .rsel     (RSEL_B),
        .rdata    (mem[RSEL_B]),
        .wr_ok    (wr_ok),
        .wsel     (WSEL),
        .wdata    (IN),
        .out      (OUT_B)
    );

endmodule

// File: tb/tb_reg_f_2r1w.sv
// Bench for reg_f_2r1w: three instances (plain, zero-register, six entries) share one stimulus.
module tb_reg_f_2r1w;

    logic       clk;
    logic       rst;
    logic       en;
    logic       wr;
    logic       clr;
    logic [2:0] wsel;
    logic [2:0] rsel_a;
    logic [2:0] rsel_b;
    logic [3:0] din;
    logic [3:0] oa [3];
    logic [3:0] ob [3];
    logic       bsy [3];

    int total = 0;
    int bad   = 0;

    // Reference state per instance: contents, remaining sweep cycles, expected outputs.
    logic [3:0] mem_m [3][8];
    int         left  [3];
    logic [3:0] ea    [3];
    logic [3:0] eb    [3];

    reg_f_2r1w #(.WIDTH(4), .SIZE(8), .ZERO_REG(1'b0)) dut_plain (
        .CLK(clk), .RST(rst), .EN(en), .WR(wr), .WSEL(wsel), .IN(din),
        .RSEL_A(rsel_a), .RSEL_B(rsel_b), .CLR(clr),
        .OUT_A(oa[0]), .OUT_B(ob[0]), .BUSY(bsy[0])
    );

    reg_f_2r1w #(.WIDTH(4), .SIZE(8), .ZERO_REG(1'b1)) dut_zero (
        .CLK(clk), .RST(rst), .EN(en), .WR(wr), .WSEL(wsel), .IN(din),
        .RSEL_A(rsel_a), .RSEL_B(rsel_b), .CLR(clr),
        .OUT_A(oa[1]), .OUT_B(ob[1]), .BUSY(bsy[1])
    );

    reg_f_2r1w #(.WIDTH(4), .SIZE(6), .ZERO_REG(1'b0)) dut_six (
        .CLK(clk), .RST(rst), .EN(en), .WR(wr), .WSEL(wsel), .IN(din),
        .RSEL_A(rsel_a), .RSEL_B(rsel_b), .CLR(clr),
        .OUT_A(oa[2]), .OUT_B(ob[2]), .BUSY(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int sz_of(input int k);
        return (k == 2) ? 6 : 8;
    endfunction

    function automatic bit zr_of(input int k);
        return (k == 1);
    endfunction

    function automatic logic [3:0] model_read(input int k, input int sel, input bit wv);
        if (sel >= sz_of(k) || (zr_of(k) && sel == 0)) return 4'h0;
        if (wv && int'(wsel) == sel) return din;
        return mem_m[k][sel];
    endfunction

    // Advance the reference by one clock edge from the current inputs, then let the DUT take the edge.
    task automatic step();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                ea[k]   = 4'h0;
                eb[k]   = 4'h0;
                left[k] = sz_of(k);
            end else if (en) begin
                if (left[k] > 0) begin
                    mem_m[k][sz_of(k) - left[k]] = 4'h0;
                    left[k] = left[k] - 1;
                    ea[k]   = 4'h0;
                    eb[k]   = 4'h0;
                end else begin
                    bit wv;
                    wv = wr && (int'(wsel) < sz_of(k)) && !(zr_of(k) && wsel == 3'd0);
                    ea[k] = model_read(k, int'(rsel_a), wv);
                    eb[k] = model_read(k, int'(rsel_b), wv);
                    if (wv) mem_m[k][wsel] = din;
                    if (clr) left[k] = sz_of(k);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; en = 1'b1; wr = 1'b0; clr = 1'b0;
        wsel = '0; rsel_a = '0; rsel_b = '0; din = '0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) mem_m[k][i] = 4'h0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bsy[k] !== 1'b1 || oa[k] !== 4'h0 || ob[k] !== 4'h0) begin
                bad++;
                $display("FAIL reset k=%0d busy=%b a=%h b=%h required busy=1 a=0 b=0", k, bsy[k], oa[k], ob[k]);
            end
        end
        n = 1;
        for (int c = 0; c < 30 && bsy[0] === 1'b1; c++) begin
            step();
            if (bsy[0] === 1'b1) n++;
        end
        total++;
        if (n != 8 || bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy_len got=%0d busy=%b required=8 busy=0", n, bsy[0]);
        end
        for (int i = 0; i < 8; i++) begin
            rsel_a = 3'(i); rsel_b = 3'(7 - i);
            step();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (oa[k] !== 4'h0 || ob[k] !== 4'h0) begin
                    bad++;
                    $display("FAIL reset_clear k=%0d i=%0d a=%h b=%h required 0 0", k, i, oa[k], ob[k]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        wr = 1'b1; wsel = 3'd0; din = 4'hF;
        step();
        for (int i = 1; i < 8; i++) begin
            wsel = 3'(i); din = 4'(i);
            step();
        end
        wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rsel_a = 3'(i); rsel_b = 3'(7 - i);
            step();
            total++;
            if (oa[1] !== 4'(i) || ob[1] !== 4'(7 - i)) begin
                bad++;
                $display("FAIL wr_rd_zero i=%0d a=%h b=%h required %h %h", i, oa[1], ob[1], 4'(i), 4'(7 - i));
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (oa[k] !== ea[k] || ob[k] !== eb[k]) begin
                    bad++;
                    $display("FAIL wr_rd k=%0d i=%0d a=%h b=%h required %h %h", k, i, oa[k], ob[k], ea[k], eb[k]);
                end
            end
        end
    endtask

    task automatic test_forward();
        wr = 1'b1; wsel = 3'd3; din = 4'h5;
        step();
        din = 4'hA; rsel_a = 3'd3; rsel_b = 3'd3;
        step();
        wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (oa[k] !== 4'hA || ob[k] !== 4'hA) begin
                bad++;
                $display("FAIL forward k=%0d a=%h b=%h required a a", k, oa[k], ob[k]);
            end
        end
        step();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (oa[k] !== 4'hA || ob[k] !== ea[k]) begin
                bad++;
                $display("FAIL forward_stored k=%0d a=%h b=%h required a %h", k, oa[k], ob[k], ea[k]);
            end
        end
    endtask

    task automatic test_en_hold();
        wr = 1'b1; wsel = 3'd2; din = 4'h6; rsel_a = 3'd2;
        step();
        wr = 1'b0;
        step();
        en = 1'b0; wr = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rsel_a = 3'($urandom_range(0, 7));
            rsel_b = 3'($urandom_range(0, 7));
            wsel   = 3'($urandom_range(0, 7));
            din    = 4'($urandom_range(0, 15));
            step();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (oa[k] !== 4'h6) begin
                    bad++;
                    $display("FAIL en_hold k=%0d c=%0d a=%h required 6", k, c, oa[k]);
                end
            end
        end
        en = 1'b1; wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rsel_a = 3'(i); rsel_b = 3'((i + 3) % 8);
            step();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (oa[k] !== ea[k] || ob[k] !== eb[k]) begin
                    bad++;
                    $display("FAIL en_hold_array k=%0d i=%0d a=%h b=%h required %h %h", k, i, oa[k], ob[k], ea[k], eb[k]);
                end
            end
        end
    endtask

    task automatic test_clear();
        int n;
        int c;
        en = 1'b1; wr = 1'b1; wsel = 3'd1; din = 4'h9; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bsy[k] !== 1'b1) begin
                bad++;
                $display("FAIL clear_start k=%0d busy=%b required 1", k, bsy[k]);
            end
        end
        n = 1;
        c = 0;
        while (c < 40 && bsy[0] === 1'b1) begin
            en   = !(c >= 2 && c <= 4);
            clr  = (c == 1);
            wsel = 3'($urandom_range(0, 7));
            din  = 4'($urandom_range(1, 15));
            step();
            if (bsy[0] === 1'b1) n++;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (oa[k] !== ea[k] || ob[k] !== eb[k] || bsy[k] !== (left[k] > 0)) begin
                    bad++;
                    $display("FAIL clear_sweep k=%0d c=%0d a=%h b=%h busy=%b required %h %h %b",
                             k, c, oa[k], ob[k], bsy[k], ea[k], eb[k], left[k] > 0);
                end
            end
            c++;
        end
        clr = 1'b0; en = 1'b1; wr = 1'b0;
        total++;
        if (n != 11 || bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL clear_busy_len got=%0d busy=%b required=11 busy=0", n, bsy[0]);
        end
        for (int i = 0; i < 8; i++) begin
            rsel_a = 3'(i); rsel_b = 3'(7 - i);
            step();
            total++;
            if (oa[0] !== 4'h0 || ob[0] !== 4'h0 || oa[1] !== 4'h0 || ob[1] !== 4'h0) begin
                bad++;
                $display("FAIL clear_zero i=%0d a0=%h b0=%h a1=%h b1=%h required all 0", i, oa[0], ob[0], oa[1], ob[1]);
            end
            total++;
            if (oa[2] !== ea[2] || ob[2] !== eb[2]) begin
                bad++;
                $display("FAIL clear_six i=%0d a=%h b=%h required %h %h", i, oa[2], ob[2], ea[2], eb[2]);
            end
        end
    endtask

    task automatic test_size6();
        en = 1'b1; wr = 1'b1; wsel = 3'd6; din = 4'hC;
        step();
        wsel = 3'd7; din = 4'hD;
        step();
        wr = 1'b0; rsel_a = 3'd6; rsel_b = 3'd7;
        step();
        total++;
        if (oa[2] !== 4'h0 || ob[2] !== 4'h0) begin
            bad++;
            $display("FAIL size6_oob a=%h b=%h required 0 0", oa[2], ob[2]);
        end
        total++;
        if (oa[0] !== 4'hC || ob[0] !== 4'hD) begin
            bad++;
            $display("FAIL size8_top a=%h b=%h required c d", oa[0], ob[0]);
        end
        for (int i = 0; i < 6; i++) begin
            rsel_a = 3'(i); rsel_b = 3'(5 - i);
            step();
            total++;
            if (oa[2] !== ea[2] || ob[2] !== eb[2]) begin
                bad++;
                $display("FAIL size6_entries i=%0d a=%h b=%h required %h %h", i, oa[2], ob[2], ea[2], eb[2]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en     = ($urandom_range(0, 9) != 0);
            wr     = $urandom_range(0, 1) != 0;
            clr    = ($urandom_range(0, 39) == 0);
            wsel   = 3'($urandom_range(0, 7));
            rsel_a = 3'($urandom_range(0, 7));
            rsel_b = ($urandom_range(0, 3) == 0) ? wsel : 3'($urandom_range(0, 7));
            din    = 4'($urandom_range(0, 15));
            step();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (oa[k] !== ea[k] || ob[k] !== eb[k] || bsy[k] !== (left[k] > 0)) begin
                    bad++;
                    $display("FAIL random k=%0d c=%0d a=%h b=%h busy=%b required %h %h %b",
                             k, c, oa[k], ob[k], bsy[k], ea[k], eb[k], left[k] > 0);
                end
            end
        end
        clr = 1'b0; wr = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_forward();
        test_en_hold();
        test_clear();
        test_size6();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_f_2r1w.md
Name: reg_f_2r1w

Overview:
- Parametrised successor to the single-port register file: one write port and two independent read ports (A, B) for the OneCycleCPU datapath (rs1/rs2 operands).
- Registered reads with write-to-read forwarding, optional hard-wired zero register.
- Sequential clear engine that sweeps all entries to zero after reset or on request, flagged by BUSY.

Parameters:
WIDTH, 4, data width in bits.
SIZE, 8, number of entries (>=2; need not be a power of two).
ZERO_REG, 0, when 1 entry 0 always reads as zero and writes to it are discarded.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  block enable; when 0, no write, no read update, clear sweep pauses.
WR  input  1  write strobe (qualified by EN).
WSEL  input  $clog2(SIZE)  write address.
IN  input  WIDTH  write data.
RSEL_A  input  $clog2(SIZE)  read address, port A.
RSEL_B  input  $clog2(SIZE)  read address, port B.
CLR  input  1  request a full clear sweep (single-cycle pulse or level).
OUT_A  output  WIDTH  registered read data, port A.
OUT_B  output  WIDTH  registered read data, port B.
BUSY  output  1  high while the clear sweep is in progress.

Behaviour:
- Reset (RST=1 at CLK edge): OUT_A=0, OUT_B=0, BUSY=1, sweep pointer=0, FSM -> CLEARING. Array contents are not reset directly; the sweep clears them. RST overrides every other input.
- FSM states: CLEARING, READY.
  - CLEARING: each edge with EN=1 writes 0 to entry[ptr] and increments ptr. When ptr==SIZE-1 is written, go to READY, BUSY=0 on the next cycle. Total sweep = SIZE enabled cycles.
  - EN=0 in CLEARING holds ptr and state.
  - READY: CLR=1 with EN=1 -> ptr=0, CLEARING, BUSY=1 next cycle. CLR is ignored while already CLEARING; the sweep does not restart.
- Write (READY, EN=1, WR=1): entry[WSEL] <= IN at the edge.
  - Ignored if WSEL >= SIZE, or if ZERO_REG=1 and WSEL==0.
  - A CLR in the same cycle as WR: the write happens first, then the sweep starts; the written value is later cleared.
- Write in CLEARING: discarded, no side effect.
- Read (EN=1, READY): at the edge, OUT_x <= entry[RSEL_x]; latency 1 cycle. Both ports are independent and may use the same address.
- Forwarding: if a valid write targets RSEL_x in the same cycle, OUT_x <= IN (new data, not old).
- Read overrides:
  - RSEL_x >= SIZE returns 0.
  - ZERO_REG=1 and RSEL_x==0 returns 0.
  - In CLEARING, OUT_A/OUT_B <= 0.
- EN=0 in READY: OUT_A/OUT_B hold their previous value; the array is unchanged.
- Address width is $clog2(SIZE), with a minimum of 1.

Decomposition:
- Shared package reg_f_pkg: FSM state enum (CLEARING, READY), function for address width with minimum 1.
- One natural sub-module: reg_f_rd_port, one read port with range check, zero-reg override and forwarding mux, instantiated twice.
- Array, write logic and clear FSM stay in the top module.

Test Plan:
1. Reset with WIDTH=4, SIZE=8: assert RST 1 cycle, EN=1 -> BUSY=1 for exactly 8 cycles, then 0. Every entry then reads 0 on both ports.
2. Write IN=1..7 to WSEL=1..7, then read RSEL_A=i, RSEL_B=7-i -> OUT_A=i, OUT_B=7-i one cycle after each address change. With ZERO_REG=1, also write 4'hF to entry 0 -> reads return 0.
3. Forwarding: entry 3 holds 4'h5; WR=1, WSEL=3, IN=4'hA, RSEL_A=RSEL_B=3 in the same cycle -> OUT_A=OUT_B=4'hA next cycle.
4. EN=0 hold: with OUT_A=4'h6, drop EN and change RSEL_A/WSEL/IN with WR=1 for 5 cycles -> OUT_A stays 4'h6, array unchanged. Re-enable and verify the old contents.
5. Mid-run clear: pulse CLR, toggle EN low for 3 cycles during the sweep, issue writes during the sweep -> BUSY lasts 8 enabled cycles (11 total), writes are lost, all entries read 0.
6. SIZE=6 instance: write and read at address 6 and 7 -> write ignored, reads return 0. Entries 0..5 are unaffected.
